wb_arbiter_2m: RTL and testbench

Two-master Wishbone arbiter that shares one slave port between the CPU data master and instruction master. It is used in front of a single BRAM/peripheral slave so that both masters can reach it without a full crossbar. Round-robin fairness, grant held for the whole bus cycle, and an optional stall watchdog.

---
 rtl/wb_arbiter_2m.sv | 120 ++++++++++++
 tb/tb_wb_arbiter_2m.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant that is held for the whole bus cycle.
// Optional stall watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_arbiter_2m #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [DATA_W-1:0]   m0_data_i,
  output logic [DATA_W-1:0]   m0_data_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [DATA_W-1:0]   m1_data_i,
  output logic [DATA_W-1:0]   m1_data_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [DATA_W-1:0]   s_data_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_ack_i,
  output logic [1:0]          gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   last_gnt;  // 0: m0 was granted last, 1: m1
  logic   req0, req1;
  logic   timeout;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last_gnt)) begin
            state    <= GNT0;
            last_gnt <= 1'b0;
          end else if (req1) begin
            state    <= GNT1;
            last_gnt <= 1'b1;
          end
        end
        // last_gnt is left on the owner so a timed-out master loses the next tie
        GNT0:    if (!m0_cyc_i || timeout) state <= IDLE;
        GNT1:    if (!m1_cyc_i || timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                     cnt <= '0;
    else if (!s_stb_o || s_ack_i)   cnt <= '0;
    else                            cnt <= cnt + CNT_W'(1);
  end

  assign timeout = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYC));
`else
  localparam int cfg_unused = TIMEOUT_CYC + CNT_W;
  assign timeout = 1'b0;
`endif

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_sel_o  = '0;
    s_data_o = '0;
    if (state == GNT0) begin
      s_cyc_o  = m0_cyc_i & ~timeout;
      s_stb_o  = m0_stb_i & ~timeout;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_sel_o  = m0_sel_i;
      s_data_o = m0_data_i;
    end else if (state == GNT1) begin
      s_cyc_o  = m1_cyc_i & ~timeout;
      s_stb_o  = m1_stb_i & ~timeout;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_sel_o  = m1_sel_i;
      s_data_o = m1_data_i;
    end
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign m0_ack_o  = s_ack_i & (state == GNT0);
  assign m1_ack_o  = s_ack_i & (state == GNT1);
  assign m0_err_o  = timeout & (state == GNT0);
  assign m1_err_o  = timeout & (state == GNT1);
  assign gnt_o     = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus randomized traffic scored against
// a transaction-level model of round-robin arbitration.
module tb_wb_arbiter_2m;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i, rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i, s_addr_o;
  logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o, s_data_o, s_data_i;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [1:0]    gnt_o;

  int checks = 0;
  int passed = 0;

  int order_q[$];
  int req_q[$];
  int idle_q[$];
  int bad;
  bit done;
  logic [AW-1:0] taddr[2];
  logic [DW-1:0] tdata[2];
  logic          twe[2];

  wb_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_sel_i(m0_sel_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_sel_i(m1_sel_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_sel_o(s_sel_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_bus();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_sel_i = '0; m0_data_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_sel_i = '0; m1_data_i = '0;
    s_ack_i = 0;
  endtask

  task automatic do_reset();
    clear_bus();
    rst_i = 0;
    tick();
    rst_i = 1;
    tick();
  endtask

  task automatic new_txn(input int x);
    taddr[x] = $urandom & 32'hFFFF_FFFC;
    tdata[x] = $urandom;
    twe[x]   = 1'($urandom_range(0, 1));
  endtask

  // Stimulus engine: two masters issuing single transfers, a slave with random wait states.
  task automatic run_traffic(input int n0, input int n1, input int lat_max, input bit rgap,
                             input int budget);
    int rem[2];
    int gap[2];
    bit cool[2];
    bit req[2];
    bit preq[2];
    int swait, lat, idle_run, o;
    logic [1:0] g, prev_g;
    logic [DW-1:0] rd;
    rem[0] = n0; rem[1] = n1;
    order_q.delete(); req_q.delete(); idle_q.delete();
    bad = 0; done = 0;
    for (int x = 0; x < 2; x++) begin
      new_txn(x); cool[x] = 0; gap[x] = 0; preq[x] = 0;
    end
    swait = 0; lat = $urandom_range(0, lat_max); idle_run = 0; prev_g = 2'b00; rd = '0;
    for (int c = 0; c < budget; c++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        req[x] = 0;
        if (rem[x] > 0) begin
          if (cool[x]) begin
            cool[x] = 0;
            gap[x] = rgap ? $urandom_range(0, 3) : 0;
          end else if (gap[x] > 0) gap[x]--;
          else req[x] = 1;
        end
      end
      m0_cyc_i = req[0]; m0_stb_i = req[0]; m0_we_i = twe[0]; m0_addr_i = taddr[0];
      m0_sel_i = '1; m0_data_i = tdata[0];
      m1_cyc_i = req[1]; m1_stb_i = req[1]; m1_we_i = twe[1]; m1_addr_i = taddr[1];
      m1_sel_i = '1; m1_data_i = tdata[1];
      #1;
      s_ack_i = 0;
      if (s_stb_o) begin
        if (swait >= lat) begin
          s_ack_i = 1; rd = $urandom; s_data_i = rd;
        end else swait++;
      end else begin
        swait = 0; lat = $urandom_range(0, lat_max);
      end
      #1;
      g = gnt_o;
      if (g != 2'b00 && prev_g == 2'b00) begin
        order_q.push_back((g == 2'b10) ? 1 : 0);
        req_q.push_back({30'd0, preq[1], preq[0]});
        if (order_q.size() > 1) idle_q.push_back(idle_run);
      end
      if (g == 2'b00) idle_run++; else idle_run = 0;
      if (g != 2'b00 && prev_g != 2'b00 && g != prev_g) bad++;
      if (s_ack_i && s_stb_o) begin
        o = (g == 2'b10) ? 1 : 0;
        if (!(g == 2'b01 || g == 2'b10) || !req[o]) bad++;
        if ((o == 0 && (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0)) ||
            (o == 1 && (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0))) bad++;
        if (s_addr_o !== taddr[o] || s_we_o !== twe[o] || (twe[o] && s_data_o !== tdata[o])) bad++;
        if (!twe[o] && ((o == 0 && m0_data_o !== rd) || (o == 1 && m1_data_o !== rd))) bad++;
        rem[o]--; cool[o] = 1; new_txn(o);
      end else if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) bad++;
      preq = req; prev_g = g;
      if (rem[0] == 0 && rem[1] == 0) begin
        done = 1;
        break;
      end
    end
    clear_bus();
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    clear_bus();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
    v = $urandom; s_data_i = v;
    rst_i = 0;
    tick();
    #1;
    checks++; if (gnt_o !== 2'b00) $display("FAIL rst_gnt got %b exp 00", gnt_o); else passed++;
    checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) $display("FAIL rst_sctl got %b exp 000", {s_cyc_o, s_stb_o, s_we_o}); else passed++;
    checks++; if (s_addr_o !== '0 || s_sel_o !== '0 || s_data_o !== '0) $display("FAIL rst_sbus got %h/%h/%h exp 0", s_addr_o, s_sel_o, s_data_o); else passed++;
    checks++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) $display("FAIL rst_ackerr got %b exp 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); else passed++;
    checks++; if (m0_data_o !== v || m1_data_o !== v) $display("FAIL rst_rdata got %h/%h exp %h", m0_data_o, m1_data_o, v); else passed++;
    clear_bus();
    rst_i = 1;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 32'h0000_0010; m0_sel_i = '1;
    #1;
    checks++; if (gnt_o !== 2'b00) $display("FAIL t1_pre_gnt got %b exp 00", gnt_o); else passed++;
    tick();
    #1;
    checks++; if (gnt_o !== 2'b01) $display("FAIL t1_gnt got %b exp 01", gnt_o); else passed++;
    checks++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_addr_o !== 32'h10 || s_we_o !== 1'b0) $display("FAIL t1_sbus got cyc%b stb%b we%b %h exp 1 1 0 00000010", s_cyc_o, s_stb_o, s_we_o, s_addr_o); else passed++;
    tick();
    s_ack_i = 1; s_data_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (m0_ack_o !== 1'b1 || m0_data_o !== 32'hDEAD_BEEF) $display("FAIL t1_ack got %b %h exp 1 deadbeef", m0_ack_o, m0_data_o); else passed++;
    checks++; if (m1_ack_o !== 1'b0) $display("FAIL t1_m1ack got %b exp 0", m1_ack_o); else passed++;
    tick();
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    #1;
    checks++; if (s_cyc_o !== 1'b0) $display("FAIL t1_drop got %b exp 0", s_cyc_o); else passed++;
    tick();
    #1;
    checks++; if (gnt_o !== 2'b00) $display("FAIL t1_idle got %b exp 00", gnt_o); else passed++;
  endtask

  task automatic test_round_robin();
    int obad, ibad;
    do_reset();
    run_traffic(4, 4, 1, 1'b0, 200);
    obad = 0; ibad = 0;
    foreach (order_q[i]) if (order_q[i] != i % 2) obad++;
    foreach (idle_q[i]) if (idle_q[i] != 1) ibad++;
    checks++; if (!done) $display("FAIL rr_done got %0d exp 1", done); else passed++;
    checks++; if (order_q.size() != 8 || obad != 0) $display("FAIL rr_order got n=%0d bad=%0d exp n=8 bad=0", order_q.size(), obad); else passed++;
    checks++; if (idle_q.size() != 7 || ibad != 0) $display("FAIL rr_idle got n=%0d bad=%0d exp n=7 bad=0", idle_q.size(), ibad); else passed++;
    checks++; if (bad != 0) $display("FAIL rr_proto got %0d exp 0", bad); else passed++;
  endtask

  task automatic test_burst_hold();
    int writes, abad, m0acks;
    logic [AW-1:0] a;
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h20; m1_sel_i = '1; m1_data_i = $urandom;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 32'h100; m0_sel_i = '1;
    writes = 0; abad = 0; m0acks = 0;
    for (int b = 0; b < 3; b++) begin
      a = 32'h20 + 32'(4 * b);
      m1_addr_i = a; m1_data_i = $urandom; s_ack_i = 1;
      #1;
      if (s_cyc_o && s_stb_o && s_we_o && s_ack_i && gnt_o == 2'b10) begin
        writes++;
        if (s_addr_o !== a || s_data_o !== m1_data_i) abad++;
      end
      if (m0_ack_o) m0acks++;
      tick();
    end
    m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
    #1;
    checks++; if (writes != 3 || abad != 0) $display("FAIL t3_writes got %0d bad=%0d exp 3 bad=0", writes, abad); else passed++;
    checks++; if (m0acks != 0 || m0_ack_o !== 1'b0) $display("FAIL t3_m0ack got %0d exp 0", m0acks); else passed++;
    checks++; if (gnt_o !== 2'b10 || s_cyc_o !== 1'b0) $display("FAIL t3_drop got gnt%b cyc%b exp 10 0", gnt_o, s_cyc_o); else passed++;
    tick();
    #1;
    checks++; if (gnt_o !== 2'b00) $display("FAIL t3_turn got %b exp 00", gnt_o); else passed++;
    tick();
    #1;
    checks++; if (gnt_o !== 2'b01 || s_addr_o !== 32'h100) $display("FAIL t3_m0gnt got %b %h exp 01 00000100", gnt_o, s_addr_o); else passed++;
    clear_bus();
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    int err_at, errs, m1errs, cyc_at_err, stalls;
    logic [1:0] gnt_hist[13];
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h40; m0_sel_i = '1;
    tick();
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h80; m1_sel_i = '1;
    err_at = -1; errs = 0; m1errs = 0; cyc_at_err = -1; stalls = 0;
    for (int k = 0; k < 13; k++) begin
      #1;
      gnt_hist[k] = gnt_o;
      if (m0_err_o === 1'b1) begin
        errs++;
        if (err_at < 0) begin err_at = k; cyc_at_err = int'(s_cyc_o); end
      end
      if (m1_err_o === 1'b1) m1errs++;
      if (s_stb_o === 1'b1 && gnt_o === 2'b01) stalls++;
      tick();
    end
`ifdef WB_ARB_WATCHDOG_EN
    checks++; if (err_at != 8) $display("FAIL wd_when got %0d exp 8", err_at); else passed++;
    checks++; if (errs != 1 || m1errs != 0) $display("FAIL wd_pulse got m0=%0d m1=%0d exp 1 0", errs, m1errs); else passed++;
    checks++; if (cyc_at_err != 0) $display("FAIL wd_cyc got %0d exp 0", cyc_at_err); else passed++;
    checks++; if (gnt_hist[9] !== 2'b00 || gnt_hist[10] !== 2'b10) $display("FAIL wd_next got %b,%b exp 00,10", gnt_hist[9], gnt_hist[10]); else passed++;
`else
    checks++; if (errs != 0 || m1errs != 0) $display("FAIL wd_off_err got %0d/%0d exp 0/0", errs, m1errs); else passed++;
    checks++; if (stalls != 13) $display("FAIL wd_off_stall got %0d exp 13", stalls); else passed++;
    checks++; if (gnt_hist[12] !== 2'b01) $display("FAIL wd_off_gnt got %b exp 01", gnt_hist[12]); else passed++;
`endif
    clear_bus();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h200; m1_sel_i = '1;
    tick();
    #1;
    checks++; if (gnt_o !== 2'b10 || s_cyc_o !== 1'b1) $display("FAIL t5_pre got %b %b exp 10 1", gnt_o, s_cyc_o); else passed++;
    rst_i = 0;
    #1;
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || gnt_o !== 2'b00) $display("FAIL t5_async got cyc%b stb%b gnt%b exp 0 0 00", s_cyc_o, s_stb_o, gnt_o); else passed++;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h300; m0_sel_i = '1;
    rst_i = 1;
    tick();
    #1;
    checks++; if (gnt_o !== 2'b01 || s_addr_o !== 32'h300) $display("FAIL t5_tie got %b %h exp 01 00000300", gnt_o, s_addr_o); else passed++;
    clear_bus();
    tick();
    tick();
  endtask

  task automatic test_early_drop();
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h400; m0_sel_i = '1;
    tick();
    #1;
    checks++; if (gnt_o !== 2'b01) $display("FAIL t6_gnt got %b exp 01", gnt_o); else passed++;
    tick();
    m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m0_ack_o !== 1'b0) $display("FAIL t6_drop got cyc%b stb%b ack%b exp 0 0 0", s_cyc_o, s_stb_o, m0_ack_o); else passed++;
    tick();
    s_ack_i = 1; s_data_i = $urandom;
    #1;
    checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) $display("FAIL t6_late got %b %b exp 0 0", m0_ack_o, m1_ack_o); else passed++;
    checks++; if (gnt_o !== 2'b00) $display("FAIL t6_idle got %b exp 00", gnt_o); else passed++;
    clear_bus();
    tick();
  endtask

  task automatic test_random();
    int n0, n1, mism, prev_win, exp_win;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      n0 = $urandom_range(5, 15);
      n1 = $urandom_range(5, 15);
      run_traffic(n0, n1, 3, 1'b1, 2000);
      // Reference: the sole requester wins; on a tie, whoever did not win last time
      mism = 0; prev_win = 1;
      foreach (order_q[i]) begin
        if (req_q[i] == 3)      exp_win = 1 - prev_win;
        else if (req_q[i] == 1) exp_win = 0;
        else                    exp_win = 1;
        if (order_q[i] != exp_win) mism++;
        prev_win = order_q[i];
      end
      checks++; if (!done) $display("FAIL rnd%0d_done got %0d exp 1", r, done); else passed++;
      checks++; if (order_q.size() != n0 + n1) $display("FAIL rnd%0d_grants got %0d exp %0d", r, order_q.size(), n0 + n1); else passed++;
      checks++; if (mism != 0) $display("FAIL rnd%0d_fair got %0d exp 0", r, mism); else passed++;
      checks++; if (bad != 0) $display("FAIL rnd%0d_proto got %0d exp 0", r, bad); else passed++;
    end
  endtask

  initial begin
    rst_i = 0;
    s_data_i = '0;
    clear_bus();
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_hold();
    test_watchdog();
    test_async_reset();
    test_early_drop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
